// File: rtl/groestl_sub_shift.sv
// Groestl-256 row-serial SubBytes + ShiftBytes: one 8-byte row per cycle passes
// through eight AES S-boxes and lands pre-rotated in the output register.
module groestl_sub_shift (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_state,
  input  logic         in_q,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   state_r;
  logic [2:0]   cnt_r;
  logic [511:0] in_reg_r;
  logic [511:0] out_reg_r;
  logic         q_reg_r;
  logic         out_valid_r;
  logic         accept_s;
  logic [7:0]   sub_row_s [8];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      else      p = p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), followed by the AES affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Q offsets 1,3,5,7,0,2,4,6 equal {r[1:0], ~r[2]}
  function automatic logic [2:0] sigma(input logic q, input logic [2:0] r);
    if (q) return {r[1:0], ~r[2]};
    else   return r;
  endfunction

  // Upstream may push only when idle, or when the finished state leaves this edge
  always_comb begin
    if (rst) begin
      in_ready = 1'b0;
    end else begin
      case (state_r)
        IDLE:    in_ready = 1'b1;
        DONE:    in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept_s = in_valid & in_ready;

  // Substituted bytes of row cnt, already in output column order
  always_comb begin
    logic [2:0] sh;
    logic [2:0] col;
    logic [5:0] k;
    sh  = sigma(q_reg_r, cnt_r);
    col = 3'd0;
    k   = 6'd0;
    for (int c = 0; c < 8; c++) begin
      col          = 3'(c) + sh;
      k            = {col, cnt_r};
      sub_row_s[c] = sbox(in_reg_r[{~k, 3'b000} +: 8]);
    end
  end

  // FSM, row counter and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 3'd0;
      in_reg_r    <= 512'd0;
      q_reg_r     <= 1'b0;
      out_reg_r   <= 512'd0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            in_reg_r <= in_state;
            q_reg_r  <= in_q;
            cnt_r    <= 3'd0;
            state_r  <= BUSY;
          end
        end
        BUSY: begin
          for (int c = 0; c < 8; c++) begin
            out_reg_r[{~{3'(c), cnt_r}, 3'b000} +: 8] <= sub_row_s[c];
          end
          cnt_r <= cnt_r + 3'd1;
          if (cnt_r == 3'd7) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (accept_s) begin
              in_reg_r <= in_state;
              q_reg_r  <= in_q;
              cnt_r    <= 3'd0;
              state_r  <= BUSY;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign out_state = out_reg_r;

endmodule

// File: tb/tb_groestl_sub_shift.sv
// Scoreboard bench for groestl_sub_shift: a table-driven reference model predicts
// every accepted state; a negedge monitor checks each output transfer.
module tb_groestl_sub_shift;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_state;
  logic         in_q;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_state;

  always #5 clk = ~clk;

  groestl_sub_shift dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_q      (in_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  localparam logic [127:0] SBOX_ROWS [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           n_xfer = 0;
  int           prev_xfer = -1;
  bit           spacing_on = 1'b0;
  logic [511:0] exp_q [$];
  int           acc;
  int           e;
  int           xb;
  logic [511:0] s;
  logic [511:0] snap;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [127:0] row;
    row = SBOX_ROWS[x[7:4]];
    return row[8 * (15 - int'(x[3:0])) +: 8];
  endfunction

  function automatic logic [7:0] get_byte(input logic [511:0] st, input int k);
    return st[511 - 8 * k -: 8];
  endfunction

  // out[row r][col c] = S(in[row r][col (c + sigma[r]) mod 8])
  function automatic logic [511:0] model(input logic [511:0] st, input logic q);
    int sig_p [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
    int sig_q [8] = '{1, 3, 5, 7, 0, 2, 4, 6};
    logic [511:0] res;
    int sg;
    res = '0;
    for (int r = 0; r < 8; r++) begin
      sg = q ? sig_q[r] : sig_p[r];
      for (int c = 0; c < 8; c++)
        res[511 - 8 * (8 * c + r) -: 8] = sbox_ref(get_byte(st, 8 * ((c + sg) % 8) + r));
    end
    return res;
  endfunction

  function automatic logic [511:0] rand_state();
    logic [511:0] st;
    for (int i = 0; i < 16; i++) st[32 * i +: 32] = $urandom;
    return st;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: no response within cycle budget", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [511:0] st, input logic q, input bit drop, output int acc_edge);
    bit ok;
    in_valid = 1'b1;
    in_state = st;
    in_q     = q;
    acc_edge = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ok = in_ready;
      if (ok) acc_edge = cyc + 1;
      step();
      if (ok) break;
    end
    if (acc_edge < 0) timeout("accept");
    if (drop) in_valid = 1'b0;
  endtask

  task automatic wait_out(output int edge_seen);
    edge_seen = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        edge_seen = cyc;
        break;
      end
    end
    if (edge_seen < 0) timeout("out_valid");
  endtask

  // Scoreboard: push predictions on accept, pop and compare on output transfer
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL xfer_unexpected: got %0h expected no transfer", out_state);
        end else begin
          chk("xfer_data", out_state, exp_q.pop_front());
        end
        if (spacing_on && prev_xfer >= 0) chk("xfer_spacing", cyc - prev_xfer, 9);
        prev_xfer = cyc;
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_state, in_q));
    end
    if (!spacing_on) prev_xfer = -1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_state = '0; in_q = 1'b0; out_ready = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_out_valid", out_valid, 1'b0);
    chk("post_rst_out_state", out_state, 512'd0);
    step();

    // All-zero P state
    send('0, 1'b0, 1'b1, acc);
    @(negedge clk);
    chk("busy_in_ready", in_ready, 1'b0);
    wait_out(e);
    chk("latency_zero", e - acc, 8);
    chk("zero_bytes", out_state, {64{8'h63}});
    step();

    // byte k = k, P then Q
    for (int k = 0; k < 64; k++) s[511 - 8 * k -: 8] = 8'(k);
    send(s, 1'b0, 1'b1, acc);
    wait_out(e);
    chk("latency_p", e - acc, 8);
    chk("p_byte0", get_byte(out_state, 0), 8'h63);
    chk("p_byte1", get_byte(out_state, 1), 8'h01);
    chk("p_byte8", get_byte(out_state, 8), 8'h30);
    step();
    send(s, 1'b1, 1'b1, acc);
    wait_out(e);
    chk("q_byte0", get_byte(out_state, 0), 8'h30);
    chk("q_byte1", get_byte(out_state, 1), 8'hd4);
    step();

    // Backpressure with a pending input
    out_ready = 1'b0;
    send(rand_state(), 1'($urandom_range(0, 1)), 1'b1, acc);
    wait_out(e);
    snap = out_state;
    step();
    in_valid = 1'b1; in_state = rand_state(); in_q = 1'($urandom_range(0, 1));
    xb = n_xfer;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_state", out_state, snap);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1'b1);
    acc = cyc + 1;
    step();
    in_valid = 1'b0;
    chk("bp_one_xfer", n_xfer - xb, 1);
    wait_out(e);
    chk("bp_latency", e - acc, 8);
    step();

    // Back-to-back random states
    spacing_on = 1'b1;
    xb = n_xfer;
    for (int i = 0; i < 4; i++) send(rand_state(), 1'($urandom_range(0, 1)), i == 3, acc);
    for (int i = 0; i < 60 && n_xfer != xb + 4; i++) @(negedge clk);
    chk("b2b_count", n_xfer - xb, 4);
    step();
    spacing_on = 1'b0;

    // Reset in BUSY cycle 4
    xb = n_xfer;
    send(rand_state(), 1'($urandom_range(0, 1)), 1'b1, acc);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    step();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("mid_rst_no_valid", out_valid, 1'b0);
      step();
    end
    chk("mid_rst_no_xfer", n_xfer - xb, 0);
    send(rand_state(), 1'($urandom_range(0, 1)), 1'b1, acc);
    wait_out(e);
    chk("post_rst_latency", e - acc, 8);
    step();
    step();
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
